switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Conditions raw board slide-switch inputs into clean, glitch-free levels for the mux stage.
//   Mapping to the mux: db_out[0]->sw0, db_out[1]->sw1, db_out[4:2]->select[2:0].
//   Each bit is handled independently:
//     - 2-flop synchronizer;
//     - stability counter; db_out updates only after the synchronized input differs from it
//       for STABLE_CYCLES consecutive clocks.
//   Sits directly upstream of the mux: board pins -> switch_debouncer -> mux.
// PARAMETERS
//   WIDTH          5    number of switch bits debounced
//   STABLE_CYCLES  16   consecutive differing cycles required to accept a new level; legal range >=1
//                       (board build overrides to 1_000_000)
//   CNT_W          derived localparam = $clog2(STABLE_CYCLES+1); per-bit counter width
// PORTS
//   clk      in   1      system clock, all logic on rising edge
//   rst      in   1      synchronous reset, active-high
//   raw_in   in   WIDTH  asynchronous raw switch levels
//   db_out   out  WIDTH  debounced levels
//   stable   out  1      1 when every bit's synchronized input equals db_out (nothing pending)
//   rise     out  WIDTH  1-cycle pulse when db_out[i] goes 0->1 (see CONFIGURATION)
//   fall     out  WIDTH  1-cycle pulse when db_out[i] goes 1->0 (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at a rising edge):
//     - sync1, sync2, db_out, all counters, rise and fall cleared to 0.
//     - stable therefore reads 1.
//     - Reset mid-count discards progress; no partial state survives.
//   Synchronizer: sync1 <= raw_in; sync2 <= sync1. Only sync2 feeds the counter logic.
//   Per bit i, each edge with rst=0:
//     - sync2[i]==db_out[i]: cnt[i] <= 0 (any bounce back restarts the count).
//     - sync2[i]!=db_out[i] and cnt[i]!=STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
//     - sync2[i]!=db_out[i] and cnt[i]==STABLE_CYCLES-1: db_out[i] <= sync2[i]; cnt[i] <= 0.
//   Latency:
//     - A raw step held steady is visible on db_out after the (STABLE_CYCLES+2)th rising edge.
//       Edge 1 is the edge that captures the new raw value into sync1.
//     - A pulse shorter than STABLE_CYCLES synchronized cycles never reaches db_out.
//   Counters never exceed STABLE_CYCLES-1 and never wrap.
//   Bits are fully independent; simultaneous changes on several bits each complete on their own schedule.
//   stable = (sync2 == db_out), combinational from registers; drops the cycle after a change reaches sync2.
// CONFIGURATION
//   SWITCH_DEBOUNCER_EDGE_EN defined:
//     - rise/fall are registered and assert for exactly one cycle, on the same edge db_out[i] changes.
//     - rise[i] set on a 0->1 change, fall[i] set on a 1->0 change; otherwise both 0.
//   SWITCH_DEBOUNCER_EDGE_EN undefined:
//     - rise and fall ports remain; both are tied to 0 and no edge registers are built.
// TESTING (bench uses STABLE_CYCLES=4, WIDTH=5)
//   1 Reset: raw_in=5'b11111, rst=1 for 3 edges -> db_out=0, rise=fall=0, stable=1 throughout reset.
//   2 Clean step: after reset, raw_in[0] 0->1 held -> db_out[0]=1 after the 6th edge (not the 5th).
//     With EDGE_EN, rise[0]=1 for that one cycle only.
//   3 Bounce: raw_in[1] pattern 1,0,1,0 (2 cycles each) then held 1 -> db_out[1] stays 0 during bounce.
//     db_out[1] rises 6 edges after final 0->1.
//   4 Glitch: raw_in[2]=1 for 3 cycles then 0 -> db_out[2] never changes; stable returns to 1.
//   5 Reset mid-count: raw_in[3]=1, rst pulsed when cnt[3]=2, raw held -> db_out[3]=0 after reset.
//     db_out[3] rises 6 edges after rst deasserts.
//   6 Multi-bit + release: raw_in=5'b10101 at once -> db_out=5'b10101 on the same edge.
//     stable=0 while counting. Then raw_in=0 -> db_out=0 after 6 edges, with EDGE_EN fall=5'b10101 one cycle.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// rtl/switch_debouncer_if.sv - switch debouncer signal bundle
// Purpose: groups raw switch levels and the debounced results into one port.
// Signals:
//   raw_in  WIDTH  asynchronous raw switch levels (driven by the board side)
//   db_out  WIDTH  debounced levels
//   stable  1      every synchronized input matches db_out
//   rise    WIDTH  one-cycle 0->1 pulse per bit (zero unless SWITCH_DEBOUNCER_EDGE_EN)
//   fall    WIDTH  one-cycle 1->0 pulse per bit (zero unless SWITCH_DEBOUNCER_EDGE_EN)
// Modports: master drives raw_in, slave is the debouncer.
interface switch_debouncer_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] db_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             stable;

    modport master (
        output raw_in,
        input  db_out,
        input  stable,
        input  rise,
        input  fall
    );

    modport slave (
        input  raw_in,
        output db_out,
        output stable,
        output rise,
        output fall
    );
endinterface

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-bit synchronizer and stability-count debouncer
// Purpose: turns raw slide-switch levels into glitch-free levels for the mux
//   stage (db_out[0]->sw0, db_out[1]->sw1, db_out[4:2]->select[2:0]).
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous reset, active-high
//   sw   slave modport of switch_debouncer_if (raw_in in; db_out, stable, rise, fall out)
// Parameters: WIDTH switch bits, STABLE_CYCLES (>=1) consecutive differing
//   synchronized cycles needed before db_out accepts a new level.
// Option: SWITCH_DEBOUNCER_EDGE_EN builds registered rise/fall pulses; when
//   undefined rise and fall are tied to zero.
module switch_debouncer #(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    switch_debouncer_if.slave sw
);
    localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_next;
    logic [CNT_W-1:0] cnt_q    [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];

    // Any cycle where the synchronized level agrees with db_out restarts the
    // count, so only an unbroken run of STABLE_CYCLES disagreements flips it.
    always_comb begin
        db_next = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1 <= sw.raw_in;
            sync2 <= sync1;
            db_q  <= db_next;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end

    assign sw.db_out = db_q;
    assign sw.stable = (sync2 == db_q);

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Registered from the same next-state as db_q so the pulse lines up
    // with the edge on which db_out changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= db_next & ~db_q;
            fall_q <= ~db_next & db_q;
        end
    end

    assign sw.rise = rise_q;
    assign sw.fall = fall_q;
`else
    assign sw.rise = '0;
    assign sw.fall = '0;
`endif
endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer
module tb_switch_debouncer;
    localparam int W = 5;
    localparam int S = 4;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    switch_debouncer_if #(.WIDTH(W)) sw ();

    switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    always #5 clk = ~clk;

    // Reference model: history of raw values captured each edge. The value
    // compared at an edge is the one captured two edges earlier; a bit flips
    // when the last S compared values all disagree with the current level.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_db   = '0;
    logic [W-1:0] m_rise = '0;
    logic [W-1:0] m_fall = '0;
    logic         m_stable = 1'b1;

    always @(posedge clk) begin
        logic [W-1:0] flip;
        int           n;
        if (rst) begin
            m_db   = '0;
            m_rise = '0;
            m_fall = '0;
            hist   = {};
            for (int k = 0; k < S + 2; k++) hist.push_back('0);
        end else begin
            n    = hist.size();
            flip = '1;
            for (int i = 0; i < W; i++) begin
                for (int k = n - 1 - S; k <= n - 2; k++) begin
                    if (hist[k][i] == m_db[i]) flip[i] = 1'b0;
                end
            end
            m_rise = EDGE ? (flip & ~m_db) : '0;
            m_fall = EDGE ? (flip & m_db) : '0;
            m_db   = m_db ^ flip;
            hist.push_back(sw.raw_in);
            if (hist.size() > S + 4) void'(hist.pop_front());
        end
        m_stable = (hist[hist.size() - 2] == m_db);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        sw.raw_in = '1;
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            total++;
            if ({sw.db_out, sw.rise, sw.fall, sw.stable} !== {15'd0, 1'b1}) begin
                bad++;
                $display("FAIL reset edge %0d: got db=%b rise=%b fall=%b stable=%b, want 0/0/0/1",
                         k, sw.db_out, sw.rise, sw.fall, sw.stable);
            end
        end
        rst = 1'b0;
        sw.raw_in = '0;
    endtask

    task automatic test_clean_step();
        repeat (3) step();
        sw.raw_in[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            total++;
            if (sw.db_out[0] !== (k >= 6)) begin
                bad++;
                $display("FAIL clean_step db0 edge %0d: got %b want %b", k, sw.db_out[0], k >= 6);
            end
            total++;
            if (sw.rise[0] !== (EDGE && k == 6)) begin
                bad++;
                $display("FAIL clean_step rise0 edge %0d: got %b want %b", k, sw.rise[0], EDGE && k == 6);
            end
            total++;
            if ({sw.db_out, sw.stable, sw.rise, sw.fall} !== {m_db, m_stable, m_rise, m_fall}) begin
                bad++;
                $display("FAIL clean_step model edge %0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                         sw.db_out, sw.stable, sw.rise, sw.fall, m_db, m_stable, m_rise, m_fall);
            end
        end
    endtask

    task automatic test_bounce();
        for (int p = 0; p < 4; p++) begin
            sw.raw_in[1] = (p % 2 == 0);
            repeat (2) begin
                step();
                total++;
                if (sw.db_out[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL bounce db1 during bounce: got %b want 0", sw.db_out[1]);
                end
            end
        end
        sw.raw_in[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if (sw.db_out[1] !== (k == 6)) begin
                bad++;
                $display("FAIL bounce db1 edge %0d after settle: got %b want %b", k, sw.db_out[1], k == 6);
            end
        end
    endtask

    task automatic test_glitch();
        bit saw_unstable = 1'b0;
        sw.raw_in[2] = 1'b1;
        repeat (3) step();
        sw.raw_in[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (sw.stable === 1'b0) saw_unstable = 1'b1;
            step();
            total++;
            if (sw.db_out[2] !== 1'b0) begin
                bad++;
                $display("FAIL glitch db2 cycle %0d: got %b want 0", k, sw.db_out[2]);
            end
        end
        total++;
        if ({saw_unstable, sw.stable} !== 2'b11) begin
            bad++;
            $display("FAIL glitch stable: saw_unstable=%b final stable=%b want 1/1", saw_unstable, sw.stable);
        end
    endtask

    task automatic test_reset_mid();
        sw.raw_in[3] = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({sw.db_out, sw.stable} !== {5'b00000, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid after reset: got db=%b stable=%b want 00000/1", sw.db_out, sw.stable);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if (sw.db_out[3] !== (k == 6)) begin
                bad++;
                $display("FAIL reset_mid db3 edge %0d: got %b want %b", k, sw.db_out[3], k == 6);
            end
        end
    endtask

    task automatic test_multi_bit();
        sw.raw_in = '0;
        repeat (10) step();
        sw.raw_in = 5'b10101;
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if ({sw.db_out, sw.stable} !== {(k == 6) ? 5'b10101 : 5'b00000, (k == 1 || k == 6)}) begin
                bad++;
                $display("FAIL multi_set edge %0d: got db=%b stable=%b want %b/%b", k, sw.db_out, sw.stable,
                         (k == 6) ? 5'b10101 : 5'b00000, (k == 1 || k == 6));
            end
        end
        sw.raw_in = '0;
        for (int k = 1; k <= 6; k++) begin
            step();
            total++;
            if ({sw.db_out, sw.fall} !== {(k == 6) ? 5'b00000 : 5'b10101, (EDGE && k == 6) ? 5'b10101 : 5'b00000}) begin
                bad++;
                $display("FAIL multi_release edge %0d: got db=%b fall=%b", k, sw.db_out, sw.fall);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            sw.raw_in = sw.raw_in ^ (W'($urandom) & W'($urandom) & W'($urandom));
            rst = ($urandom_range(0, 79) == 0);
            step();
            total++;
            if ({sw.db_out, sw.stable, sw.rise, sw.fall} !== {m_db, m_stable, m_rise, m_fall}) begin
                bad++;
                $display("FAIL random cycle %0d: got %b/%b/%b/%b want %b/%b/%b/%b", k,
                         sw.db_out, sw.stable, sw.rise, sw.fall, m_db, m_stable, m_rise, m_fall);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        sw.raw_in = '1;
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_multi_bit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
